div_sequencer: RTL and testbench

Multi-cycle integer divide controller for the execute stage. Accepts one DIV/DIVU/REM/REMU operation (64-bit or W form) through a valid/ready handshake, runs a radix-2 restoring iteration one quotient bit per cycle, applies RISC-V sign and special-case rules, and holds the result until the pipeline takes it. While it is busy, the execute stage stalls; `busy` feeds the same hazard/bubble network as the decode-stage operand logic.

---
 rtl/div_sequencer_if.sv | 27 ++
 rtl/div_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_div_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_sequencer_if.sv
// Request/response bundle for the multi-cycle divider: operation request, flush,
// result handshake and the busy/stall indication.
interface div_sequencer_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      op;
    logic            word;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, op, word, a, b, flush, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, word, a, b, flush, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/div_sequencer.sv
// Radix-2 restoring DIV/DIVU/REM/REMU (64-bit and W forms) with RISC-V special cases.
// Optional DIV_FAST_ZERO_EN: a zero divisor skips the iteration and completes in one cycle.
module div_sequencer #(
    parameter int XLEN = 64
) (
    input logic            clk,
    input logic            reset,
    div_sequencer_if.slave bus
);
    localparam int HALF = XLEN / 2;
    localparam int CW   = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_reg;
    logic            sel_rem_reg;
    logic            word_reg;
    logic            neg_q_reg;
    logic            neg_r_reg;
    logic            zero_reg;
    logic [XLEN-1:0] divisor_reg;
    logic [XLEN-1:0] dividend_reg;
    logic [XLEN-1:0] rem_reg;
    logic [XLEN-1:0] quot_reg;
    logic [XLEN-1:0] result_reg;
    logic [CW-1:0]   count_reg;
    logic            in_ready_reg;
    logic            out_valid_reg;
    logic            busy_reg;

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.busy      = busy_reg;
    assign bus.result    = result_reg;

    // Operand conditioning at accept: extension, magnitudes and sign flags.
    logic            is_signed;
    logic [XLEN-1:0] a_ext;
    logic [XLEN-1:0] b_ext;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            b_zero;

    assign is_signed = ~bus.op[0];

    always_comb begin
        a_ext = bus.a;
        b_ext = bus.b;
        if (bus.word) begin
            a_ext = {{HALF{is_signed & bus.a[HALF-1]}}, bus.a[HALF-1:0]};
            b_ext = {{HALF{is_signed & bus.b[HALF-1]}}, bus.b[HALF-1:0]};
        end
    end

    assign a_neg  = is_signed & a_ext[XLEN-1];
    assign b_neg  = is_signed & b_ext[XLEN-1];
    assign a_mag  = a_neg ? (~a_ext + 1'b1) : a_ext;
    assign b_mag  = b_neg ? (~b_ext + 1'b1) : b_ext;
    assign b_zero = (b_ext == {XLEN{1'b0}});

    // One restoring step; the extra top bit of the trial difference is the borrow.
    logic [XLEN:0]   partial;
    logic [XLEN:0]   trial;
    logic            no_borrow;
    logic [XLEN-1:0] rem_step;
    logic [XLEN-1:0] quot_step;

    assign partial   = {rem_reg, quot_reg[XLEN-1]};
    assign trial     = partial - {1'b0, divisor_reg};
    assign no_borrow = ~trial[XLEN];
    assign rem_step  = no_borrow ? trial[XLEN-1:0] : partial[XLEN-1:0];
    assign quot_step = {quot_reg[XLEN-2:0], no_borrow};

    function automatic logic [XLEN-1:0] final_result(
        input logic            sel_rem,
        input logic            word_f,
        input logic            neg_q,
        input logic            neg_r,
        input logic            zero_f,
        input logic [XLEN-1:0] q,
        input logic [XLEN-1:0] r,
        input logic [XLEN-1:0] dvd
    );
        logic [XLEN-1:0] qs;
        logic [XLEN-1:0] rs;
        logic [XLEN-1:0] sel;
        qs = neg_q ? (~q + 1'b1) : q;
        rs = neg_r ? (~r + 1'b1) : r;
        if (zero_f) begin
            qs = {XLEN{1'b1}};
            rs = dvd;
        end
        sel = sel_rem ? rs : qs;
        if (word_f) begin
            sel = {{HALF{sel[HALF-1]}}, sel[HALF-1:0]};
        end
        return sel;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            sel_rem_reg   <= 1'b0;
            word_reg      <= 1'b0;
            neg_q_reg     <= 1'b0;
            neg_r_reg     <= 1'b0;
            zero_reg      <= 1'b0;
            divisor_reg   <= '0;
            dividend_reg  <= '0;
            rem_reg       <= '0;
            quot_reg      <= '0;
            result_reg    <= '0;
            count_reg     <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else if (bus.flush) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        sel_rem_reg  <= bus.op[1];
                        word_reg     <= bus.word;
                        neg_q_reg    <= a_neg ^ b_neg;
                        neg_r_reg    <= a_neg;
                        zero_reg     <= b_zero;
                        divisor_reg  <= b_mag;
                        dividend_reg <= a_ext;
                        rem_reg      <= '0;
                        // W forms are left-aligned so only HALF steps are needed.
                        quot_reg     <= bus.word ? {a_mag[HALF-1:0], {HALF{1'b0}}} : a_mag;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
`ifdef DIV_FAST_ZERO_EN
                        if (b_zero) begin
                            state_reg     <= DONE;
                            count_reg     <= '0;
                            out_valid_reg <= 1'b1;
                            result_reg    <= final_result(bus.op[1], bus.word, 1'b0, 1'b0, 1'b1,
                                                          {XLEN{1'b0}}, {XLEN{1'b0}}, a_ext);
                        end else begin
                            state_reg <= RUN;
                            count_reg <= bus.word ? CW'(HALF) : CW'(XLEN);
                        end
`else
                        state_reg <= RUN;
                        count_reg <= bus.word ? CW'(HALF) : CW'(XLEN);
`endif
                    end
                end
                RUN: begin
                    rem_reg   <= rem_step;
                    quot_reg  <= quot_step;
                    count_reg <= count_reg - 1'b1;
                    if (count_reg == CW'(1)) begin
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                        result_reg    <= final_result(sel_rem_reg, word_reg, neg_q_reg, neg_r_reg,
                                                      zero_reg, quot_step, rem_step, dividend_reg);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_reg     <= IDLE;
                        in_ready_reg  <= 1'b1;
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: directed RISC-V corner cases, flush/reset aborts,
// backpressure, back-to-back issue and random operations against a behavioural model.
module tb_div_sequencer;
    logic clk;
    logic reset;

    div_sequencer_if #(.XLEN(64)) bus ();

    div_sequencer #(.XLEN(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   checks;
    int   fails;

    function automatic logic [63:0] ref_div(input logic [1:0] op, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [31:0] a32;
        logic [31:0] b32;
        logic [31:0] r32;
        logic [63:0] r64;
        a32 = a[31:0];
        b32 = b[31:0];
        if (w) begin
            if (b32 == 32'd0)
                r32 = op[1] ? a32 : 32'hFFFF_FFFF;
            else if (!op[0] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF)
                r32 = op[1] ? 32'd0 : 32'h8000_0000;
            else begin
                case (op)
                    2'd0: r32 = $signed(a32) / $signed(b32);
                    2'd1: r32 = a32 / b32;
                    2'd2: r32 = $signed(a32) % $signed(b32);
                    default: r32 = a32 % b32;
                endcase
            end
            return {{32{r32[31]}}, r32};
        end
        if (b == 64'd0)
            r64 = op[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
        else if (!op[0] && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)
            r64 = op[1] ? 64'd0 : 64'h8000_0000_0000_0000;
        else begin
            case (op)
                2'd0: r64 = $signed(a) / $signed(b);
                2'd1: r64 = a / b;
                2'd2: r64 = $signed(a) % $signed(b);
                default: r64 = a % b;
            endcase
        end
        return r64;
    endfunction

    function automatic int exp_lat(input logic w, input logic [63:0] b);
        logic zero;
        zero = w ? (b[31:0] == 32'd0) : (b == 64'd0);
`ifdef DIV_FAST_ZERO_EN
        if (zero) return 1;
`else
        if (zero) return w ? 33 : 65;
`endif
        return w ? 33 : 65;
    endfunction

    // Issue one op, wait for the result, hold it for 'hold' cycles, then consume it.
    task automatic run_op(input string name, input logic [1:0] op, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] expect_res, input int hold);
        exp_t        e;
        int          waited;
        int          lat;
        logic [63:0] held;
        waited = 0;
        while (bus.in_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s accept: in_ready=%0b required 1", name, bus.in_ready);
            return;
        end
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.word     = w;
        bus.a        = a;
        bus.b        = b;
        e.res        = expect_res;
        e.lat        = exp_lat(w, b);
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        e = sb_q.pop_front();
        checks++;
        if (lat !== e.lat) begin
            fails++;
            $display("FAIL %s latency: got %0d required %0d", name, lat, e.lat);
        end
        checks++;
        if (bus.result !== e.res) begin
            fails++;
            $display("FAIL %s result: got %h required %h", name, bus.result, e.res);
        end
        held = e.res;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.result !== held || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
                fails++;
                $display("FAIL %s hold%0d: ov=%0b res=%h ir=%0b busy=%0b required 1 %h 0 1",
                         name, i, bus.out_valid, bus.result, bus.in_ready, bus.busy, held);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s release: ir=%0b busy=%0b ov=%0b required 1 0 0",
                     name, bus.in_ready, bus.busy, bus.out_valid);
        end
        $display("op %s op=%0d w=%0b a=%h b=%h res=%h lat=%0d", name, op, w, a, b, bus.result, lat);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 64'd0) begin
            fails++;
            $display("FAIL reset: ir=%0b ov=%0b busy=%0b res=%h required 1 0 0 0",
                     bus.in_ready, bus.out_valid, bus.busy, bus.result);
        end
        reset = 1'b0;
        @(negedge clk);
        $display("reset released");
    endtask

    task automatic test_signed();
        run_op("div_m20_3", 2'd0, 1'b0, -64'sd20, 64'sd3, 64'hFFFF_FFFF_FFFF_FFFA, 0);
        run_op("rem_m20_3", 2'd2, 1'b0, -64'sd20, 64'sd3, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    endtask

    task automatic test_word();
        run_op("divuw", 2'd1, 1'b1, 64'hFFFF_FFFF_0000_0010, 64'h2, 64'h8, 0);
        run_op("divw_neg", 2'd0, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'h2, 64'hFFFF_FFFF_FFFF_FFFD, 0);
    endtask

    task automatic test_overflow();
        run_op("div_ovf", 2'd0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, 0);
        run_op("remw_ovf", 2'd2, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0, 0);
        run_op("divw_ovf", 2'd0, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 0);
    endtask

    task automatic test_div_zero();
        run_op("divu_z", 2'd1, 1'b0, 64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op("rem_z", 2'd2, 1'b0, -64'sd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9, 0);
        run_op("divw_z", 2'd0, 1'b1, 64'h5, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op("remuw_z", 2'd3, 1'b1, 64'h1_8000_0001, 64'h0, 64'hFFFF_FFFF_8000_0001, 0);
    endtask

    task automatic test_flush_reset();
        int seen;
        // flush coincident with in_valid must not start an operation
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        bus.op       = 2'd0;
        bus.word     = 1'b0;
        bus.a        = 64'd100;
        bus.b        = 64'd7;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush_accept: busy=%0b ir=%0b required 0 1", bus.busy, bus.in_ready);
        end
        // flush in cycle 10 of a running DIV
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_idle: ir=%0b busy=%0b ov=%0b required 1 0 0",
                     bus.in_ready, bus.busy, bus.out_valid);
        end
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL flush_no_result: out_valid cycles=%0d required 0", seen);
        end
        $display("flush at cycle 10 checked");
        // reset in cycle 20 of a second op
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.result !== 64'd0) begin
            fails++;
            $display("FAIL reset_midrun: ir=%0b ov=%0b busy=%0b res=%h required 1 0 0 0",
                     bus.in_ready, bus.out_valid, bus.busy, bus.result);
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL reset_no_result: out_valid cycles=%0d required 0", seen);
        end
        $display("reset at cycle 20 checked");
    endtask

    task automatic test_backpressure();
        run_op("divu_hold", 2'd1, 1'b0, 64'd1000, 64'd7, 64'd142, 10);
    endtask

    task automatic test_back_to_back();
        run_op("remu_b2b0", 2'd3, 1'b0, 64'd1000, 64'd7, 64'd6, 0);
        run_op("div_b2b1", 2'd0, 1'b0, 64'd1000, -64'sd7, 64'hFFFF_FFFF_FFFF_FF72, 0);
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            w  = 1'($urandom_range(0, 1));
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            case (i % 4)
                1: b = b >> $urandom_range(0, 62);
                2: b = {{32{b[15]}}, 16'h0, b[15:0]};
                3: a = {{32{a[31]}}, a[31:0]};
                default: ;
            endcase
            if (i == 5) b = 64'd0;
            run_op("random", op, w, a, b, ref_div(op, w, a, b), i % 3);
        end
    endtask

    initial begin
        checks        = 0;
        fails         = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = 2'd0;
        bus.word      = 1'b0;
        bus.a         = 64'd0;
        bus.b         = 64'd0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_signed();
        test_word();
        test_overflow();
        test_div_zero();
        test_flush_reset();
        test_backpressure();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
